// File: rtl/pacote_pkg.sv
// Shared definitions for the weight-frame parser: ASCII codes, FSM states, abort causes.
package pacote_pkg;

    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAMPO = 2'd1,
        FIM   = 2'd2
    } estado_t;

    localparam logic [1:0] ERR_CHAR    = 2'b01;
    localparam logic [1:0] ERR_TERM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    function automatic logic ehDigito(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear; fim flags the terminal count while counting.
module contador_m #(
    parameter int unsigned M = 100,
    parameter int unsigned N = $clog2(M)
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);

    logic [N-1:0] q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (zera_s) begin
            q <= '0;
        end else if (conta) begin
            q <= (q == N'(M - 1)) ? '0 : q + N'(1);
        end
    end

    assign fim = conta && (q == N'(M - 1));

endmodule

// File: rtl/receptor_pacote_peso.sv
// Assembles "#" + max + min + current digits + LF into three weight fields,
// publishing only complete frames and aborting on bad bytes or inter-byte timeout.
module receptor_pacote_peso
    import pacote_pkg::*;
#(
    parameter int unsigned DIGITS       = 2,
    parameter int unsigned TIMEOUT_CLKS = 5_000_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx_valid,
    input  logic [7:0]          rx_byte,
    output logic [8*DIGITS-1:0] peso_max,
    output logic [8*DIGITS-1:0] peso_min,
    output logic [8*DIGITS-1:0] peso_atual,
    output logic                frame_valid,
    output logic                erro,
    output logic [1:0]          erro_cod,
    output logic                ocupado
);

    localparam int unsigned NSLOTS = 3 * DIGITS;
    localparam int unsigned IW     = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

    estado_t       estado;
    logic [IW-1:0] idx;
    logic [7:0]    sombra [NSLOTS];
    logic          zeraTimer;
    logic          contaTimer;
    logic          timeoutFim;

    assign zeraTimer  = rx_valid || (estado == IDLE);
    assign contaTimer = (estado != IDLE);

    contador_m #(
        .M(TIMEOUT_CLKS),
        .N($clog2(TIMEOUT_CLKS))
    ) uTimeout (
        .clock (clock),
        .reset (reset),
        .zera_s(zeraTimer),
        .conta (contaTimer),
        .fim   (timeoutFim)
    );

    // A received byte always wins over a coincident timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= IDLE;
            idx         <= '0;
            peso_max    <= '0;
            peso_min    <= '0;
            peso_atual  <= '0;
            frame_valid <= 1'b0;
            erro        <= 1'b0;
            erro_cod    <= 2'b00;
            ocupado     <= 1'b0;
            for (int i = 0; i < NSLOTS; i++) sombra[i] <= '0;
        end else begin
            frame_valid <= 1'b0;
            erro        <= 1'b0;
            unique case (estado)
                IDLE: begin
                    if (rx_valid && rx_byte == ASCII_HASH) begin
                        estado  <= CAMPO;
                        idx     <= '0;
                        ocupado <= 1'b1;
                        for (int i = 0; i < NSLOTS; i++) sombra[i] <= '0;
                    end
                end
                CAMPO: begin
                    if (rx_valid) begin
                        if (rx_byte == ASCII_HASH) begin
                            idx <= '0;
                            for (int i = 0; i < NSLOTS; i++) sombra[i] <= '0;
                        end else if (ehDigito(rx_byte)) begin
                            sombra[idx] <= rx_byte - ASCII_0;
                            if (idx == IW'(NSLOTS - 1)) estado <= FIM;
                            else                        idx    <= idx + IW'(1);
                        end else begin
                            estado   <= IDLE;
                            ocupado  <= 1'b0;
                            erro     <= 1'b1;
                            erro_cod <= ERR_CHAR;
                        end
                    end else if (timeoutFim) begin
                        estado   <= IDLE;
                        ocupado  <= 1'b0;
                        erro     <= 1'b1;
                        erro_cod <= ERR_TIMEOUT;
                    end
                end
                FIM: begin
                    if (rx_valid) begin
                        if (rx_byte == ASCII_HASH) begin
                            estado <= CAMPO;
                            idx    <= '0;
                            for (int i = 0; i < NSLOTS; i++) sombra[i] <= '0;
                        end else if (rx_byte == ASCII_LF) begin
                            for (int i = 0; i < DIGITS; i++) begin
                                peso_max  [8*(DIGITS-1-i) +: 8] <= sombra[i];
                                peso_min  [8*(DIGITS-1-i) +: 8] <= sombra[DIGITS + i];
                                peso_atual[8*(DIGITS-1-i) +: 8] <= sombra[2*DIGITS + i];
                            end
                            estado      <= IDLE;
                            ocupado     <= 1'b0;
                            frame_valid <= 1'b1;
                        end else begin
                            estado   <= IDLE;
                            ocupado  <= 1'b0;
                            erro     <= 1'b1;
                            erro_cod <= ERR_TERM;
                        end
                    end else if (timeoutFim) begin
                        estado   <= IDLE;
                        ocupado  <= 1'b0;
                        erro     <= 1'b1;
                        erro_cod <= ERR_TIMEOUT;
                    end
                end
                default: begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receptor_pacote_peso.sv
// Bench for receptor_pacote_peso: frame table, timeout/reset sequences, random traffic vs a queue model.
module tb_receptor_pacote_peso;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned TMO    = 100;
    localparam int unsigned NSLOTS = 3 * DIGITS;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte  = 8'h00;
    logic [15:0] peso_max, peso_min, peso_atual;
    logic        frame_valid, erro, ocupado;
    logic [1:0]  erro_cod;

    always #10 clock = ~clock;

    receptor_pacote_peso #(.DIGITS(DIGITS), .TIMEOUT_CLKS(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .peso_max   (peso_max),
        .peso_min   (peso_min),
        .peso_atual (peso_atual),
        .frame_valid(frame_valid),
        .erro       (erro),
        .erro_cod   (erro_cod),
        .ocupado    (ocupado)
    );

    int passCnt  = 0;
    int totalCnt = 0;
    int fvSeen   = 0;
    int erroSeen = 0;

    // Reference model: frame-in-progress flag, received digits, idle cycles since last byte.
    bit          mInFrame = 0;
    logic [7:0]  mDigits[$];
    int          mIdle = 0;
    logic [15:0] mMax = '0, mMin = '0, mAtual = '0;
    logic [1:0]  mCod = '0;
    logic        mFv = 0, mErro = 0;

    typedef struct {
        string       quadro;
        logic [15:0] eMax;
        logic [15:0] eMin;
        logic [15:0] eAtual;
        int          eFv;
        int          eErro;
        logic [1:0]  eCod;
    } vetor_t;

    vetor_t tab[6];

    task automatic check(input string nome, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", nome, act, exp);
    endtask

    task automatic modelReset();
        mInFrame = 0; mDigits.delete(); mIdle = 0;
        mMax = '0; mMin = '0; mAtual = '0; mCod = '0; mFv = 0; mErro = 0;
    endtask

    task automatic modelStep(input logic v, input logic [7:0] b);
        mFv = 0; mErro = 0;
        if (!mInFrame) begin
            if (v && b == 8'h23) begin mInFrame = 1; mDigits.delete(); mIdle = 0; end
        end else if (v) begin
            mIdle = 0;
            if (b == 8'h23) mDigits.delete();
            else if (mDigits.size() < NSLOTS && b >= 8'h30 && b <= 8'h39) mDigits.push_back(b - 8'h30);
            else if (mDigits.size() == NSLOTS && b == 8'h0A) begin
                mMax = '0; mMin = '0; mAtual = '0;
                for (int i = 0; i < DIGITS; i++) begin
                    mMax   = (mMax   << 8) | 16'(mDigits[i]);
                    mMin   = (mMin   << 8) | 16'(mDigits[DIGITS + i]);
                    mAtual = (mAtual << 8) | 16'(mDigits[2*DIGITS + i]);
                end
                mFv = 1; mInFrame = 0;
            end else begin
                mErro = 1; mInFrame = 0;
                mCod = (mDigits.size() == NSLOTS) ? 2'b10 : 2'b01;
            end
        end else begin
            mIdle++;
            if (mIdle == TMO) begin mErro = 1; mCod = 2'b11; mInFrame = 0; end
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_byte  = b;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        modelStep(v, b);
        if (frame_valid) fvSeen++;
        if (erro) erroSeen++;
        check("ciclo {max,min,atual,fv,erro,cod,ocupado}",
              64'({peso_max, peso_min, peso_atual, frame_valid, erro, erro_cod, ocupado}),
              64'({mMax, mMin, mAtual, mFv, mErro, mCod, mInFrame}));
    endtask

    task automatic sendStr(input string s);
        for (int i = 0; i < s.len(); i++) tick(1'b1, 8'(s[i]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    initial begin
        tab[0] = '{"#452012\n",    16'h0405, 16'h0200, 16'h0102, 1, 0, 2'b00};
        tab[1] = '{"#45A",         16'h0405, 16'h0200, 16'h0102, 0, 1, 2'b01};
        tab[2] = '{"#990000\n",    16'h0909, 16'h0000, 16'h0000, 1, 0, 2'b01};
        tab[3] = '{"#123456X",     16'h0909, 16'h0000, 16'h0000, 0, 1, 2'b10};
        tab[4] = '{"#12#334455\n", 16'h0303, 16'h0404, 16'h0505, 1, 0, 2'b10};
        tab[5] = '{"AB\n#987654\n",16'h0908, 16'h0706, 16'h0504, 1, 0, 2'b10};

        #5;
        check("reset outputs", 64'({peso_max, peso_min, peso_atual, frame_valid, erro, erro_cod, ocupado}), 64'(0));
        #10;
        reset = 1'b1;

        for (int r = 0; r < 6; r++) begin
            fvSeen = 0; erroSeen = 0;
            sendStr(tab[r].quadro);
            idle(3);
            check($sformatf("tab%0d peso_max", r),   64'(peso_max),   64'(tab[r].eMax));
            check($sformatf("tab%0d peso_min", r),   64'(peso_min),   64'(tab[r].eMin));
            check($sformatf("tab%0d peso_atual", r), 64'(peso_atual), 64'(tab[r].eAtual));
            check($sformatf("tab%0d frame_valid pulses", r), 64'(fvSeen),   64'(tab[r].eFv));
            check($sformatf("tab%0d erro pulses", r),        64'(erroSeen), 64'(tab[r].eErro));
            check($sformatf("tab%0d erro_cod", r),   64'(erro_cod),   64'(tab[r].eCod));
        end

        // Timeout fires on the 100th edge after the last accepted byte.
        erroSeen = 0;
        sendStr("#12");
        idle(TMO - 1);
        check("timeout early erro", 64'(erroSeen), 64'(0));
        check("timeout early ocupado", 64'(ocupado), 64'(1));
        idle(1);
        check("timeout erro", 64'(erro), 64'(1));
        check("timeout erro_cod", 64'(erro_cod), 64'(2'b11));
        check("timeout ocupado", 64'(ocupado), 64'(0));

        // Bytes arriving one cycle before, and exactly on, the terminal count keep the frame alive.
        fvSeen = 0; erroSeen = 0;
        sendStr("#12");
        idle(TMO - 2);
        tick(1'b1, "3");
        idle(TMO - 1);
        tick(1'b1, "4");
        sendStr("56\n");
        idle(2);
        check("late bytes erro pulses", 64'(erroSeen), 64'(0));
        check("late bytes frame_valid pulses", 64'(fvSeen), 64'(1));
        check("late bytes fields", 64'({peso_max, peso_min, peso_atual}), 64'(48'h0102_0304_0506));

        // Asynchronous reset mid-frame.
        sendStr("#1234");
        #3;
        reset = 1'b0;
        #1;
        check("async reset outputs", 64'({peso_max, peso_min, peso_atual, frame_valid, erro, erro_cod, ocupado}), 64'(0));
        modelReset();
        #2;
        reset = 1'b1;
        fvSeen = 0;
        sendStr("#000001\n");
        idle(1);
        check("post-reset frame_valid pulses", 64'(fvSeen), 64'(1));
        check("post-reset fields", 64'({peso_max, peso_min, peso_atual}), 64'(48'h0000_0000_0001));

        // Random traffic checked cycle by cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 2) begin
                idle(int'($urandom_range(95, 105)));
            end else begin
                logic       v;
                logic [7:0] b;
                int         r;
                v = ($urandom_range(0, 3) != 0);
                r = int'($urandom_range(0, 19));
                if (r < 2)       b = 8'h23;
                else if (r < 14) b = 8'h30 + 8'($urandom_range(0, 9));
                else if (r < 16) b = 8'h0A;
                else             b = 8'($urandom);
                tick(v, b);
            end
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/receptor_pacote_peso.md
# receptor_pacote_peso

Frame parser between the UART receiver (`rx_serial_8N1_nandland`, 115200 baud at 50 MHz) and the weight-sorting datapath. It assembles one ASCII frame `#` + max + min + current weight digits + LF into three digit-per-byte weight fields. It validates every byte and enforces an inter-byte timeout. Only complete, well-formed frames are published, with a one-cycle `frame_valid` pulse, so the comparators and servo logic never see partially shifted data.

## Interface
- `DIGITS`, 2: decimal digits per weight field; field width is 8*DIGITS
- `TIMEOUT_CLKS`, 5_000_000: idle clocks allowed between bytes inside a frame (100 ms at 50 MHz)
- `clock` in 1: system clock, 50 MHz; one clock domain
- `reset` in 1: asynchronous, active-low reset
- `rx_valid` in 1: one-cycle strobe from the UART, byte available
- `rx_byte` in 8: received ASCII byte, sampled only when `rx_valid`=1
- `peso_max` out 8*DIGITS: max weight, MSD in the top byte, each byte 0..9
- `peso_min` out 8*DIGITS: min weight, same format
- `peso_atual` out 8*DIGITS: current weight, same format
- `frame_valid` out 1: one-cycle pulse when the fields are updated
- `erro` out 1: one-cycle pulse when a frame is aborted
- `erro_cod` out 2: cause of the last abort; held until the next abort or reset
- `ocupado` out 1: high while a frame is in progress

## Operation
- FSM states: IDLE, CAMPO, FIM.
- IDLE:
  - `rx_valid` with 0x23 (`#`) -> CAMPO, with digit index 0 and the shadow buffer cleared.
  - Any other byte is ignored, with no error.
- CAMPO:
  - Each `rx_valid` with 0x30..0x39 stores `rx_byte - 0x30` into shadow slot `idx`, then increments `idx`.
  - Field order is max, min, current; MSD first within each field.
  - After storing digit 3*DIGITS-1 -> FIM.
- FIM:
  - 0x0A -> copy the shadow buffer to the output fields, pulse `frame_valid`, go to IDLE.
- Errors:
  - A byte that is neither a digit nor `#` in CAMPO -> `erro_cod`=01.
  - A non-LF byte other than `#` in FIM -> `erro_cod`=10.
  - Timeout in CAMPO/FIM -> `erro_cod`=11.
  - Each error pulses `erro` and returns to IDLE; the output fields are unchanged.
- `#` received in CAMPO or FIM restarts the frame: `idx`=0, shadow buffer cleared, stay in/enter CAMPO, no error.
- The timeout counter runs only in CAMPO/FIM and clears on every `rx_valid`. Reaching TIMEOUT_CLKS-1 without `rx_valid` triggers the timeout error.
- If `rx_valid` arrives in the same cycle the counter hits terminal, the byte is processed and no timeout occurs.
- `ocupado` = (state != IDLE).

## Timing
- Reset values: all fields 0, `frame_valid`=0, `erro`=0, `erro_cod`=00, `ocupado`=0, state IDLE, `idx`=0, timeout counter 0.
- All outputs are registered. The fields and `frame_valid` change on the clock edge that samples the LF `rx_valid`, so they are visible the next cycle.
- `frame_valid` and `erro` last exactly one cycle and are never high together.
- Back-to-back `rx_valid` on consecutive cycles are accepted; the block has no backpressure.
- Reset asserted mid-frame discards the frame and drives all outputs to reset values immediately (asynchronously).
- Minimum frame: 3*DIGITS+2 strobes.
- Timeout fires TIMEOUT_CLKS cycles after the last accepted byte.

## Structure
- Shared package `pacote_pkg`:
  - ASCII constants `ASCII_HASH`=8'h23, `ASCII_LF`=8'h0A, `ASCII_0`=8'h30, `ASCII_9`=8'h39.
  - FSM state typedef.
  - Error code constants `ERR_CHAR`=2'b01, `ERR_TERM`=2'b10, `ERR_TIMEOUT`=2'b11.
- Timeout counter: instance of the existing `contador_m`.
  - M=TIMEOUT_CLKS, N=$clog2(TIMEOUT_CLKS).
  - `zera_s` = `rx_valid` | (state==IDLE); `conta` = (state!=IDLE); `fim` is the timeout.
- FSM, shadow buffer (3*DIGITS bytes) and index register are written directly in the top module.

## Test plan
- Frame "#452012\n" with DIGITS=2 -> one `frame_valid`; `peso_max`=16'h0405, `peso_min`=16'h0200, `peso_atual`=16'h0102; `erro` never pulses.
- "#45A" -> `erro` pulse with `erro_cod`=01. A following "#990000\n" -> `peso_max`=16'h0909, `peso_min`=16'h0000, `peso_atual`=16'h0000.
- "#123456X" -> `erro_cod`=10; fields keep their previous values; no `frame_valid`.
- With TIMEOUT_CLKS=100: "#12", then 100 idle cycles -> `erro` with `erro_cod`=11 exactly 100 cycles after the '2' strobe.
  - Repeat with a '3' strobe on cycle 99 -> no timeout.
- "#12#334455\n" -> restart without error; `peso_max`=16'h0303, `peso_min`=16'h0404, `peso_atual`=16'h0505.
- Reset pulsed low after "#1234" -> all outputs 0. Then "#000001\n" -> `peso_atual`=16'h0001 with `frame_valid`.
